// File: rtl/mcs51_timer_array_pkg.sv
// Shared definitions for the multi-channel MCS-51 timer/counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mcs51_timer_pkg;

    // Classic 8051 TMOD mode encoding
    typedef enum logic [1:0] {
        M13    = 2'd0,  // 13-bit prescaled
        M16    = 2'd1,  // full-width
        M8RL   = 2'd2,  // auto-reload
        MSPLIT = 2'd3   // split TH/TL
    } tmode_e;

    // Flops in each pin synchroniser
    localparam int SYNC_DEPTH = 2;

    // Channel-select width; a single channel still gets a 1-bit select
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcs51_timer_array_if.sv
// CPU write port into the timer TH/TL registers.
// Latency: a write lands in the register on the clock it is presented.
// Backpressure: none; the timer accepts a write every cycle.
// Signals: wr_en strobe, wr_ch channel, wr_hi (1 = TH, 0 = TL), wr_data.
interface mcs51_timer_array_if #(
    parameter int NUM_CH = 2,
    parameter int HW     = 8
);
    import mcs51_timer_pkg::*;

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic            wr_en;
    logic [CH_W-1:0] wr_ch;
    logic            wr_hi;
    logic [HW-1:0]   wr_data;

    modport master (output wr_en, wr_ch, wr_hi, wr_data);
    modport slave  (input  wr_en, wr_ch, wr_hi, wr_data);

endinterface

// File: rtl/mcs51_timer_ch.sv
// One timer/counter channel: pin synchronisers, mode counters, sticky flags.
// Latency: count visible 1 clk after inc; t_pin fall to count 3 clks.
// Backpressure: none; CPU writes override the addressed half immediately.
// Ports: tick (shared prescaler), run controls, pins, per-half write, cnt/tf/tf_hi.
module mcs51_timer_ch
    import mcs51_timer_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int PRE_W = 5,
    localparam int HW   = CNT_W / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             tr,
    input  logic             gate,
    input  logic             c_t,
    input  logic [1:0]       mode,
    input  logic             t_pin,
    input  logic             int_pin,
    input  logic             tf_clr,
    input  logic             wr_tl,
    input  logic             wr_th,
    input  logic [HW-1:0]    wr_data,
    output logic [CNT_W-1:0] cnt,
    output logic             tf,
    output logic             tf_hi
);

    // Bits of TL that form the mode-0 prescaler field
    localparam logic [HW-1:0] FMASK = HW'((1 << PRE_W) - 1);

    logic [HW-1:0]         tl, th, tl_n, th_n;
    logic [SYNC_DEPTH-1:0] t_sync, int_sync;
    logic                  t_last;
    logic                  t_s, int_s, fe, run, inc, th_tick;
    logic                  tf_set, tfh_set;
    tmode_e                m;

    assign t_s     = t_sync[SYNC_DEPTH-1];
    assign int_s   = int_sync[SYNC_DEPTH-1];
    assign fe      = t_last & ~t_s;
    assign run     = tr & (~gate | int_s);
    assign inc     = run & (c_t ? fe : tick);
    // Split-mode TH ignores gate and c_t entirely
    assign th_tick = tr & tick;
    assign m       = tmode_e'(mode);

    always_comb begin
        tl_n    = tl;
        th_n    = th;
        tf_set  = 1'b0;
        tfh_set = 1'b0;
        case (m)
            M13: begin
                // Upper TL bits above the field are held untouched
                tl_n = (tl & ~FMASK) | ((tl + HW'(inc)) & FMASK);
                if (inc && ((tl & FMASK) == FMASK)) begin
                    th_n   = th + HW'(1);
                    tf_set = &th;
                end
            end
            M16: begin
                {th_n, tl_n} = {th, tl} + CNT_W'(inc);
                tf_set       = inc & (&{th, tl});
            end
            M8RL: begin
                if (inc) begin
                    if (&tl) begin
                        tl_n   = th;
                        tf_set = 1'b1;
                    end else begin
                        tl_n = tl + HW'(1);
                    end
                end
            end
            default: begin
                tl_n    = tl + HW'(inc);
                tf_set  = inc & (&tl);
                th_n    = th + HW'(th_tick);
                tfh_set = th_tick & (&th);
            end
        endcase
        // CPU write beats counting for its half; any carry into it is lost,
        // while the flag still reflects the counting that happened.
        if (wr_tl) tl_n = wr_data;
        if (wr_th) th_n = wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tl       <= '0;
            th       <= '0;
            tf       <= 1'b0;
            tf_hi    <= 1'b0;
            t_sync   <= '0;
            int_sync <= '0;
            t_last   <= 1'b0;
        end else begin
            tl       <= tl_n;
            th       <= th_n;
            // Set beats clear when both land in the same cycle
            tf       <= tf_set  | (tf    & ~tf_clr);
            tf_hi    <= tfh_set | (tf_hi & ~tf_clr);
            t_sync   <= {t_sync[SYNC_DEPTH-2:0], t_pin};
            int_sync <= {int_sync[SYNC_DEPTH-2:0], int_pin};
            t_last   <= t_s;
        end
    end

    assign cnt = {th, tl};

endmodule

// File: rtl/mcs51_timer_array.sv
// Multi-channel MCS-51 timer/counter: shared prescaler, write decode, channel array.
// Latency: first tick DIV clks after reset release; counts 1 clk after inc.
// Backpressure: none; writes accepted every cycle, flags held until tf_clr.
// Ports: clk/rst_n, cpu write interface, per-channel controls and pins, cnt_q/tf/tf_hi.
module mcs51_timer_array
    import mcs51_timer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int PRE_W  = 5,
    parameter int DIV    = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mcs51_timer_array_if.slave      cpu,
    input  logic [NUM_CH-1:0]       tr,
    input  logic [NUM_CH-1:0]       gate,
    input  logic [NUM_CH-1:0]       c_t,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [NUM_CH-1:0]       t_pin,
    input  logic [NUM_CH-1:0]       int_pin,
    input  logic [NUM_CH-1:0]       tf_clr,
    output logic [NUM_CH*CNT_W-1:0] cnt_q,
    output logic [NUM_CH-1:0]       tf,
    output logic [NUM_CH-1:0]       tf_hi
);

    localparam int HW     = CNT_W / 2;
    localparam int CH_W   = ch_idx_w(NUM_CH);
    localparam int PRE_CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_CW-1:0] pre;
    logic              tick;

    // Machine-cycle prescaler shared by every channel
    assign tick = (pre == PRE_CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)    pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + PRE_CW'(1);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = cpu.wr_en && (cpu.wr_ch == CH_W'(i));

        mcs51_timer_ch #(
            .CNT_W (CNT_W),
            .PRE_W (PRE_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .tr      (tr[i]),
            .gate    (gate[i]),
            .c_t     (c_t[i]),
            .mode    (mode[2*i +: 2]),
            .t_pin   (t_pin[i]),
            .int_pin (int_pin[i]),
            .tf_clr  (tf_clr[i]),
            .wr_tl   (sel & ~cpu.wr_hi),
            .wr_th   (sel &  cpu.wr_hi),
            .wr_data (cpu.wr_data[HW-1:0]),
            .cnt     (cnt_q[i*CNT_W +: CNT_W]),
            .tf      (tf[i]),
            .tf_hi   (tf_hi[i])
        );
    end

endmodule

// File: tb/tb_mcs51_timer_array.sv
// Directed bench for mcs51_timer_array: expectations queued with target cycle,
// an independent negedge monitor pops and compares them against the outputs.
module tb_mcs51_timer_array;
    import mcs51_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  tr, gate, c_t, t_pin, int_pin, tf_clr;
    logic [3:0]  mode;
    logic [31:0] cnt_q;
    logic [1:0]  tf, tf_hi;

    always #5 clk = ~clk;

    mcs51_timer_array_if #(.NUM_CH(2), .HW(8)) cpu ();

    mcs51_timer_array #(
        .NUM_CH (2),
        .CNT_W  (16),
        .PRE_W  (5),
        .DIV    (12)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cpu     (cpu),
        .tr      (tr),
        .gate    (gate),
        .c_t     (c_t),
        .mode    (mode),
        .t_pin   (t_pin),
        .int_pin (int_pin),
        .tf_clr  (tf_clr),
        .cnt_q   (cnt_q),
        .tf      (tf),
        .tf_hi   (tf_hi)
    );

    typedef struct {
        int          at;
        int          ch;
        logic [15:0] cnt;
        logic        f;
        logic        fh;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   r;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation whose target cycle has arrived
    initial begin : mon
        exp_t        e;
        logic [15:0] got;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e   = sb.pop_front();
                got = cnt_q[e.ch*16 +: 16];
                checks++;
                if (e.at != cyc) begin
                    errors++;
                    $display("FAIL check%0d ch%0d: sample cycle %0d missed (now %0d)", e.id, e.ch, e.at, cyc);
                end else if (got !== e.cnt || tf[e.ch] !== e.f || tf_hi[e.ch] !== e.fh) begin
                    errors++;
                    $display("FAIL check%0d ch%0d cyc %0d: got cnt=%h tf=%b tf_hi=%b, expected cnt=%h tf=%b tf_hi=%b",
                             e.id, e.ch, cyc, got, tf[e.ch], tf_hi[e.ch], e.cnt, e.f, e.fh);
                end
            end
        end
    end

    task automatic expect_at(input int at, input int ch, input logic [15:0] c,
                             input logic f, input logic fh, input int id);
        exp_t e;
        e.at = at; e.ch = ch; e.cnt = c; e.f = f; e.fh = fh; e.id = id;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic ch, input logic hi, input logic [7:0] d);
        cpu.wr_en = 1'b1; cpu.wr_ch = ch; cpu.wr_hi = hi; cpu.wr_data = d;
        step(1);
        cpu.wr_en = 1'b0;
    endtask

    // Two reset clocks; r marks the cycle reset is released (prescaler at 0)
    task automatic do_reset(input int t);
        rst_n = 1'b0;
        tr = '0; gate = '0; c_t = '0; t_pin = '0; int_pin = '0; tf_clr = '0; mode = '0;
        cpu.wr_en = 1'b0; cpu.wr_ch = 1'b0; cpu.wr_hi = 1'b0; cpu.wr_data = '0;
        step(2);
        rst_n = 1'b1;
        r = cyc;
        expect_at(r, 0, 16'h0000, 1'b0, 1'b0, t*100);
        expect_at(r, 1, 16'h0000, 1'b0, 1'b0, t*100 + 1);
    endtask

    initial begin
        // Mode 1 overflow and flag clear; ticks land on cycles r+12k
        do_reset(1);
        mode = 4'b0101;
        cpu_write(1'b0, 1'b1, 8'hFF);
        cpu_write(1'b0, 1'b0, 8'hFE);
        tr = 2'b01;
        expect_at(r+11, 0, 16'hFFFE, 0, 0, 102);
        expect_at(r+12, 0, 16'hFFFF, 0, 0, 103);
        expect_at(r+23, 0, 16'hFFFF, 0, 0, 104);
        expect_at(r+24, 0, 16'h0000, 1, 0, 105);
        expect_at(r+24, 1, 16'h0000, 0, 0, 106);
        expect_at(r+25, 0, 16'h0000, 0, 0, 107);
        goto(r+24);
        tf_clr = 2'b01;
        step(1);
        tf_clr = 2'b00;
        goto(r+27);

        // Mode 0: 5-bit field from 5 wraps after 27 ticks, TL[7:5] held
        do_reset(2);
        mode = 4'b0000;
        cpu_write(1'b0, 1'b1, 8'hFF);
        cpu_write(1'b0, 1'b0, 8'hE5);
        tr = 2'b01;
        expect_at(r+12,  0, 16'hFFE6, 0, 0, 202);
        expect_at(r+312, 0, 16'hFFFF, 0, 0, 203);
        expect_at(r+324, 0, 16'h00E0, 1, 0, 204);
        goto(r+326);

        // Mode 2 auto-reload from TH
        do_reset(3);
        mode = 4'b0010;
        cpu_write(1'b0, 1'b1, 8'hF0);
        cpu_write(1'b0, 1'b0, 8'hFE);
        tr = 2'b01;
        expect_at(r+12,  0, 16'hF0FF, 0, 0, 302);
        expect_at(r+24,  0, 16'hF0F0, 1, 0, 303);
        expect_at(r+204, 0, 16'hF0FF, 1, 0, 304);
        expect_at(r+216, 0, 16'hF0F0, 1, 0, 305);
        goto(r+218);

        // Counter mode on channel 1: five 2-high/2-low pulses, count 3 clks after each fall
        do_reset(4);
        mode = 4'b0101;
        c_t  = 2'b10;
        tr   = 2'b10;
        for (int j = 0; j < 5; j++) begin
            expect_at(r+4 + 4*j + 4, 1, 16'(j),     0, 0, 402 + 2*j);
            expect_at(r+4 + 4*j + 5, 1, 16'(j + 1), 0, 0, 403 + 2*j);
        end
        expect_at(r+26, 0, 16'h0000, 0, 0, 412);
        expect_at(r+26, 1, 16'h0005, 0, 0, 413);
        for (int j = 0; j < 5; j++) begin
            goto(r+4 + 4*j);
            t_pin[1] = 1'b1;
            goto(r+4 + 4*j + 2);
            t_pin[1] = 1'b0;
        end
        goto(r+28);

        // Gate held low blocks counting; int_pin rise counts on the first tick 2 clks later
        do_reset(5);
        mode = 4'b0101;
        gate = 2'b01;
        tr   = 2'b01;
        expect_at(r+60,  0, 16'h0000, 0, 0, 502);
        expect_at(r+120, 0, 16'h0000, 0, 0, 503);
        expect_at(r+131, 0, 16'h0000, 0, 0, 504);
        expect_at(r+132, 0, 16'h0001, 0, 0, 505);
        expect_at(r+144, 0, 16'h0002, 0, 0, 506);
        goto(r+129);
        int_pin[0] = 1'b1;
        goto(r+146);

        // Overflowing tick, TL write and tf_clr in the same cycle
        do_reset(6);
        mode = 4'b0101;
        cpu_write(1'b0, 1'b1, 8'hFF);
        cpu_write(1'b0, 1'b0, 8'hFF);
        tr = 2'b01;
        expect_at(r+11, 0, 16'hFFFF, 0, 0, 602);
        expect_at(r+12, 0, 16'h0055, 1, 0, 603);
        expect_at(r+24, 0, 16'h0056, 1, 0, 604);
        goto(r+11);
        cpu.wr_en = 1'b1; cpu.wr_ch = 1'b0; cpu.wr_hi = 1'b0; cpu.wr_data = 8'h55;
        tf_clr = 2'b01;
        step(1);
        cpu.wr_en = 1'b0;
        tf_clr = 2'b00;
        goto(r+26);

        // Split mode: TH runs on tr alone; mode change keeps contents and stops TH
        do_reset(7);
        mode = 4'b1111;
        cpu_write(1'b0, 1'b1, 8'hFF);
        cpu_write(1'b0, 1'b0, 8'h00);
        cpu_write(1'b1, 1'b1, 8'h00);
        cpu_write(1'b1, 1'b0, 8'hFF);
        gate = 2'b01;
        tr   = 2'b11;
        expect_at(r+12, 0, 16'h0000, 0, 1, 702);
        expect_at(r+12, 1, 16'h0100, 1, 0, 703);
        expect_at(r+24, 0, 16'h0100, 0, 1, 704);
        expect_at(r+24, 1, 16'h0201, 1, 0, 705);
        expect_at(r+36, 0, 16'h0100, 0, 1, 706);
        expect_at(r+36, 1, 16'h0302, 1, 0, 707);
        goto(r+24);
        mode = 4'b1101;
        goto(r+38);

        step(2);
        if (sb.size() > 0) begin
            $display("FAIL leftover: %0d expectations never sampled, expected 0", sb.size());
            checks += sb.size();
            errors += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcs51_timer_array.md
# mcs51_timer_array

Parametrised multi-channel timer/counter for the 8051 core, replacing the single-channel down-counting timer. Each channel implements the classic MCS-51 up-counting modes: 13-bit prescaled, full-width, auto-reload and split. Each channel also has a gate input, a synchronised external count pin and a sticky overflow flag. The block sits beside the SFR file: the CPU writes TH/TL through a write port, and the interrupt controller consumes the flags.

## Interface
- NUM_CH, 2: number of timer channels.
- CNT_W, 16: counter width per channel; must be even. Halves are TH/TL of HW = CNT_W/2 bits each.
- PRE_W, 5: active TL bits in mode 0; must be ≤ HW.
- DIV, 12: clocks per timer tick (machine cycle); must be ≥ 1.

- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- wr_en  in  1  CPU write strobe
- wr_ch  in  $clog2(NUM_CH) (min 1)  target channel
- wr_hi  in  1  1 = write TH, 0 = write TL
- wr_data  in  HW  write data
- tr  in  NUM_CH  run enable per channel
- gate  in  NUM_CH  1 = also require int_pin high to run
- c_t  in  NUM_CH  1 = count external pin edges; 0 = count ticks
- mode  in  2*NUM_CH  per-channel mode, channel i at [2i+1:2i]
- t_pin  in  NUM_CH  external count inputs (asynchronous)
- int_pin  in  NUM_CH  external gate inputs (asynchronous)
- tf_clr  in  NUM_CH  clear overflow flag (interrupt acknowledge or CPU write)
- cnt_q  out  NUM_CH*CNT_W  counter values, channel i at {TH,TL} slice i
- tf  out  NUM_CH  main overflow flag
- tf_hi  out  NUM_CH  TH overflow flag (mode 3 only)

## Operation
- Prescaler: a shared counter 0..DIV-1. It pulses `tick` for one clock when it equals DIV-1, then wraps to 0.
- Synchronisers: t_pin and int_pin each pass through 2 flops. A count event `fe` is the falling edge 1→0 of the synchronised t_pin.
- Increment event: inc = run & (c_t ? fe : tick), where run = tr & (~gate | int_sync).
- mode 0 (prescaled):
  - TL[PRE_W-1:0] increments on inc.
  - TH increments when the TL field wraps.
  - TL[HW-1:PRE_W] hold their value.
  - tf sets when TH wraps.
- mode 1: {TH,TL} is one CNT_W-bit up-counter; tf sets on wrap from all-ones to 0.
- mode 2 (auto-reload): TL increments; on TL wrap it loads TH instead of 0, and tf sets. TH is never modified by counting.
- mode 3 (split):
  - TL is an independent HW-bit counter under the normal run/c_t controls; it sets tf on wrap.
  - TH counts ticks whenever tr is 1, ignoring gate and c_t; it sets tf_hi on wrap.
- CPU write vs count in the same cycle: the write wins for the addressed half. Any carry into that half is discarded. The other half still updates normally.
- Flags:
  - Set wins over tf_clr in the same cycle.
  - Flags stay set until cleared.
  - tf_hi is not set outside mode 3.
- A mode change takes effect on the next clock. Counter contents are preserved.

## Timing
- Reset values:
  - cnt_q = 0, tf = 0, tf_hi = 0.
  - Prescaler = 0.
  - All synchroniser flops = 0, so no spurious edge after reset.
- Reset applies mid-count in one clock with no residual increment.
- Timer mode:
  - The first tick occurs DIV clocks after reset release.
  - A counter update is visible on cnt_q the clock after inc.
  - The flag is visible in the same cycle as the wrapped count value.
- Counter mode: latency from a t_pin fall to the cnt_q change is 3 clocks. The pin must hold each level for ≥ 2 clocks to be guaranteed counted.
- Gate: a change on int_pin affects counting after 2 clocks of synchronisation.
- Written values appear on cnt_q the next clock.

## Structure
- Package mcs51_timer_pkg holds:
  - the mode enum (M13 = 0, M16 = 1, M8RL = 2, MSPLIT = 3);
  - the 2-flop synchroniser depth constant.
- Sub-module mcs51_timer_ch is instantiated NUM_CH times. It contains one channel's counter, mode logic, flags and synchronisers.
- The top level contains the prescaler, write decode and vector packing.

## Test plan
- Mode 1, DIV = 12, write TH = 0xFF, TL = 0xFE, tr = 1 → after 24 clocks cnt_q = 0x0000 and tf = 1; tf_clr → tf = 0 the next clock.
- Mode 0, TH = 0xFF, TL = 0xE5 (field 0x05 wraps at 0x1F) → after 27 ticks TL = 0xE0, TH = 0x00, tf = 1. TL[7:5] stay 0b111.
- Mode 2, TH = 0xF0, TL = 0xFE → after 2 ticks TL = 0xF0, TH = 0xF0, tf = 1. After 16 more ticks TL = 0xF0 again.
- Counter mode, c_t = 1: drive 5 pulses of 2 clocks high, 2 clocks low on t_pin → cnt_q increments by 5, each 3 clocks after its falling edge.
- Gate = 1, int_pin = 0 → no counting for 100 clocks. Raise int_pin → counting resumes on the first tick from 2 clocks after.
- Mode 1, count 0xFFFF with an overflowing tick, a TL write of 0x55 and tf_clr all in the same cycle → TL = 0x55, TH = 0x00, tf = 1.
